// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: decode inputs, forwarding sources
// and EX-side outputs grouped for the stage and its driver.
interface id_ex_operand_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 4
);
  logic                  id_valid;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic [DATA_W-1:0]     id_imm;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_write_reg;
  logic [4:0]            id_shamt;
  logic [CTRL_W-1:0]     id_alu_control;
  logic                  id_alu_src;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_mem_to_reg;
  logic                  flush;
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_write_reg;
  logic [DATA_W-1:0]     exmem_alu_out;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_write_reg;
  logic [DATA_W-1:0]     memwb_data;
  logic                  stall;
  logic [DATA_W-1:0]     ALU_reg_1;
  logic [DATA_W-1:0]     ALU_reg_2;
  logic [CTRL_W-1:0]     ALU_control;
  logic [4:0]            shamt;
  logic [DATA_W-1:0]     ex_store_data;
  logic                  ex_valid;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic [REG_ADDR_W-1:0] ex_write_reg;

  modport slave (
    input  id_valid, id_rs_data, id_rt_data,
    input  id_imm, id_rs, id_rt, id_write_reg,
    input  id_shamt, id_alu_control, id_alu_src,
    input  id_reg_write, id_mem_read,
    input  id_mem_write, id_mem_to_reg, flush,
    input  exmem_reg_write, exmem_write_reg,
    input  exmem_alu_out, memwb_reg_write,
    input  memwb_write_reg, memwb_data,
    output stall, ALU_reg_1, ALU_reg_2,
    output ALU_control, shamt, ex_store_data,
    output ex_valid, ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_mem_to_reg,
    output ex_write_reg
  );

  modport master (
    output id_valid, id_rs_data, id_rt_data,
    output id_imm, id_rs, id_rt, id_write_reg,
    output id_shamt, id_alu_control, id_alu_src,
    output id_reg_write, id_mem_read,
    output id_mem_write, id_mem_to_reg, flush,
    output exmem_reg_write, exmem_write_reg,
    output exmem_alu_out, memwb_reg_write,
    output memwb_write_reg, memwb_data,
    input  stall, ALU_reg_1, ALU_reg_2,
    input  ALU_control, shamt, ex_store_data,
    input  ex_valid, ex_reg_write, ex_mem_read,
    input  ex_mem_write, ex_mem_to_reg,
    input  ex_write_reg
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use detection and
// EX/MEM, MEM/WB operand forwarding in front of the ALU.
module id_ex_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 4
) (
  input logic clk,
  input logic rst_n,
  id_ex_operand_stage_if.slave bus
);
  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [4:0]            shamt;
    logic [CTRL_W-1:0]     alu_control;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } id_ex_t;

  id_ex_t ex_q, ex_d;
  logic   hazard;
  logic   bubble;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  // Load in EX whose result the decode instruction needs.
  assign hazard = bus.id_valid & ex_q.valid &
                  ex_q.mem_read &
                  (ex_q.write_reg != '0) &
                  ((bus.id_rs == ex_q.write_reg) |
                   (bus.id_rt == ex_q.write_reg)) &
                  ~bus.flush;
  assign bus.stall = hazard;
  assign bubble    = bus.flush | hazard;

  // Next register contents: bubble, or decode fields.
  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid       = bus.id_valid;
      ex_d.rs_data     = bus.id_rs_data;
      ex_d.rt_data     = bus.id_rt_data;
      ex_d.imm         = bus.id_imm;
      ex_d.rs          = bus.id_rs;
      ex_d.rt          = bus.id_rt;
      ex_d.write_reg   = bus.id_write_reg;
      ex_d.shamt       = bus.id_shamt;
      ex_d.alu_control = bus.id_alu_control;
      ex_d.alu_src     = bus.id_alu_src;
      ex_d.reg_write   = bus.id_reg_write & bus.id_valid;
      ex_d.mem_read    = bus.id_mem_read & bus.id_valid;
      ex_d.mem_write   = bus.id_mem_write & bus.id_valid;
      ex_d.mem_to_reg  = bus.id_mem_to_reg;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [DATA_W-1:0]     rf
  );
    if (bus.exmem_reg_write &&
        bus.exmem_write_reg != '0 &&
        bus.exmem_write_reg == idx)
      return bus.exmem_alu_out;
    else if (bus.memwb_reg_write &&
             bus.memwb_write_reg != '0 &&
             bus.memwb_write_reg == idx)
      return bus.memwb_data;
    else
      return rf;
  endfunction

  // Operand forwarding, EX/MEM before MEM/WB.
  always_comb begin
    fwd_a = fwd(ex_q.rs, ex_q.rs_data);
    fwd_b = fwd(ex_q.rt, ex_q.rt_data);
  end

  assign bus.ALU_reg_1     = fwd_a;
  assign bus.ALU_reg_2     = ex_q.alu_src ? ex_q.imm
                                          : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.ALU_control   = ex_q.alu_control;
  assign bus.shamt         = ex_q.shamt;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_write_reg  = ex_q.write_reg;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, pass-through,
// forwarding priority, load-use stall, flush, store data.
module tb_id_ex_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  id_ex_operand_stage_if bus();

  id_ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear;
    bus.id_valid       = 1'b0;
    bus.id_rs_data     = '0;
    bus.id_rt_data     = '0;
    bus.id_imm         = '0;
    bus.id_rs          = '0;
    bus.id_rt          = '0;
    bus.id_write_reg   = '0;
    bus.id_shamt       = '0;
    bus.id_alu_control = '0;
    bus.id_alu_src     = 1'b0;
    bus.id_reg_write   = 1'b0;
    bus.id_mem_read    = 1'b0;
    bus.id_mem_write   = 1'b0;
    bus.id_mem_to_reg  = 1'b0;
  endtask

  task automatic fw_clear;
    bus.exmem_reg_write = 1'b0;
    bus.exmem_write_reg = '0;
    bus.exmem_alu_out   = '0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_write_reg = '0;
    bus.memwb_data      = '0;
  endtask

  initial begin
    id_clear();
    fw_clear();
    bus.flush = 1'b0;
    #1;
    chk("rst0_valid", {31'b0, bus.ex_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Pass-through, register operand B.
    bus.id_valid       = 1'b1;
    bus.id_rs_data     = 32'd5;
    bus.id_rt_data     = 32'd7;
    bus.id_imm         = 32'hFFFF_FFFC;
    bus.id_rs          = 5'd1;
    bus.id_rt          = 5'd2;
    bus.id_write_reg   = 5'd3;
    bus.id_shamt       = 5'd4;
    bus.id_alu_control = 4'b0010;
    bus.id_reg_write   = 1'b1;
    edge1();
    chk("pt_a", bus.ALU_reg_1, 32'd5);
    chk("pt_b", bus.ALU_reg_2, 32'd7);
    chk("pt_ctrl", {28'b0, bus.ALU_control}, 32'd2);
    chk("pt_shamt", {27'b0, bus.shamt}, 32'd4);
    chk("pt_valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("pt_rw", {31'b0, bus.ex_reg_write}, 32'd1);
    chk("pt_wr", {27'b0, bus.ex_write_reg}, 32'd3);

    // Immediate operand B.
    bus.id_alu_src = 1'b1;
    edge1();
    chk("imm_b", bus.ALU_reg_2, 32'hFFFF_FFFC);
    chk("imm_a", bus.ALU_reg_1, 32'd5);
    chk("imm_sd", bus.ex_store_data, 32'd7);

    // Asynchronous reset mid-cycle, all id_* nonzero.
    bus.id_mem_read   = 1'b1;
    bus.id_mem_write  = 1'b1;
    bus.id_mem_to_reg = 1'b1;
    bus.id_rs_data    = 32'd9;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a", bus.ALU_reg_1, 32'd0);
    chk("rst_b", bus.ALU_reg_2, 32'd0);
    chk("rst_sd", bus.ex_store_data, 32'd0);
    chk("rst_ctrl", {28'b0, bus.ALU_control}, 32'd0);
    chk("rst_shamt", {27'b0, bus.shamt}, 32'd0);
    chk("rst_ctl", {27'b0, bus.ex_valid,
         bus.ex_reg_write, bus.ex_mem_read,
         bus.ex_mem_write, bus.ex_mem_to_reg}, 32'd0);
    chk("rst_wr", {27'b0, bus.ex_write_reg}, 32'd0);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    #1 rst_n = 1'b1;
    edge1();
    chk("rel_a", bus.ALU_reg_1, 32'd9);
    chk("rel_mr", {31'b0, bus.ex_mem_read}, 32'd1);
    chk("rel_m2r", {31'b0, bus.ex_mem_to_reg}, 32'd1);

    // Forwarding priority.
    id_clear();
    bus.id_valid   = 1'b1;
    bus.id_rs      = 5'd8;
    bus.id_rt      = 5'd8;
    bus.id_rs_data = 32'h100;
    bus.id_rt_data = 32'h200;
    edge1();
    bus.exmem_reg_write = 1'b1;
    bus.exmem_write_reg = 5'd8;
    bus.exmem_alu_out   = 32'h11;
    bus.memwb_reg_write = 1'b1;
    bus.memwb_write_reg = 5'd8;
    bus.memwb_data      = 32'h22;
    #1;
    chk("fw_ex_a", bus.ALU_reg_1, 32'h11);
    chk("fw_ex_b", bus.ALU_reg_2, 32'h11);
    bus.exmem_reg_write = 1'b0;
    #1;
    chk("fw_wb_a", bus.ALU_reg_1, 32'h22);
    chk("fw_wb_b", bus.ALU_reg_2, 32'h22);
    bus.id_rs = 5'd0;
    bus.id_rt = 5'd0;
    bus.exmem_reg_write = 1'b1;
    bus.exmem_write_reg = 5'd0;
    bus.memwb_write_reg = 5'd0;
    edge1();
    chk("fw_r0_a", bus.ALU_reg_1, 32'h100);
    chk("fw_r0_b", bus.ALU_reg_2, 32'h200);
    fw_clear();

    // Load-use hazard.
    id_clear();
    bus.id_valid     = 1'b1;
    bus.id_mem_read  = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_write_reg = 5'd9;
    bus.id_rs        = 5'd1;
    bus.id_rt        = 5'd2;
    edge1();
    id_clear();
    bus.id_valid     = 1'b1;
    bus.id_rs        = 5'd4;
    bus.id_rt        = 5'd9;
    bus.id_rt_data   = 32'h7;
    bus.id_reg_write = 1'b1;
    bus.id_mem_write = 1'b1;
    #1;
    chk("lu_stall", {31'b0, bus.stall}, 32'd1);
    edge1();
    chk("lu_bub_v", {31'b0, bus.ex_valid}, 32'd0);
    chk("lu_bub_rw", {31'b0, bus.ex_reg_write}, 32'd0);
    chk("lu_bub_mw", {31'b0, bus.ex_mem_write}, 32'd0);
    chk("lu_stall0", {31'b0, bus.stall}, 32'd0);
    edge1();
    bus.memwb_reg_write = 1'b1;
    bus.memwb_write_reg = 5'd9;
    bus.memwb_data      = 32'hABCD;
    #1;
    chk("lu_fwd_b", bus.ALU_reg_2, 32'hABCD);
    chk("lu_go_v", {31'b0, bus.ex_valid}, 32'd1);
    fw_clear();

    // Flush overrides stall.
    id_clear();
    bus.id_valid     = 1'b1;
    bus.id_mem_read  = 1'b1;
    bus.id_write_reg = 5'd9;
    edge1();
    id_clear();
    bus.id_valid       = 1'b1;
    bus.id_rt          = 5'd9;
    bus.id_alu_control = 4'b0110;
    bus.id_reg_write   = 1'b1;
    bus.flush          = 1'b1;
    #1;
    chk("fl_stall", {31'b0, bus.stall}, 32'd0);
    edge1();
    chk("fl_v", {31'b0, bus.ex_valid}, 32'd0);
    chk("fl_ctrl", {28'b0, bus.ALU_control}, 32'd0);
    chk("fl_mr", {31'b0, bus.ex_mem_read}, 32'd0);
    bus.id_rt = 5'd3;
    edge1();
    chk("fl2_v", {31'b0, bus.ex_valid}, 32'd0);
    chk("fl2_rw", {31'b0, bus.ex_reg_write}, 32'd0);
    bus.flush = 1'b0;

    // Store data forwarding with immediate B.
    id_clear();
    bus.id_valid     = 1'b1;
    bus.id_alu_src   = 1'b1;
    bus.id_imm       = 32'h10;
    bus.id_rt        = 5'd5;
    bus.id_rt_data   = 32'h99;
    bus.id_mem_write = 1'b1;
    edge1();
    bus.exmem_reg_write = 1'b1;
    bus.exmem_write_reg = 5'd5;
    bus.exmem_alu_out   = 32'h55;
    #1;
    chk("sw_b", bus.ALU_reg_2, 32'h10);
    chk("sw_sd", bus.ex_store_data, 32'h55);
    chk("sw_mw", {31'b0, bus.ex_mem_write}, 32'd1);
    fw_clear();

    // Invalid decode slot masks side effects.
    id_clear();
    bus.id_reg_write  = 1'b1;
    bus.id_mem_read   = 1'b1;
    bus.id_mem_write  = 1'b1;
    bus.id_write_reg  = 5'd7;
    bus.id_rs_data    = 32'h33;
    edge1();
    chk("inv_ctl", {28'b0, bus.ex_valid,
         bus.ex_reg_write, bus.ex_mem_read,
         bus.ex_mem_write}, 32'd0);
    chk("inv_wr", {27'b0, bus.ex_write_reg}, 32'd7);
    chk("inv_a", bus.ALU_reg_1, 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU. It captures decoded operands and control from the decode stage every cycle. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and drives the ALU operand, control and shift-amount inputs. It also detects load-use hazards and inserts bubbles on stall or flush.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register-file address width
CTRL_W, 4, ALU control code width

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decode stage holds a real instruction
id_rs_data  input  DATA_W  register-file read data for rs
id_rt_data  input  DATA_W  register-file read data for rt
id_imm  input  DATA_W  sign-extended immediate
id_rs  input  REG_ADDR_W  rs index
id_rt  input  REG_ADDR_W  rt index
id_write_reg  input  REG_ADDR_W  destination index (already rd/rt-selected)
id_shamt  input  5  shift amount field
id_alu_control  input  CTRL_W  ALU operation code
id_alu_src  input  1  1 = second operand is the immediate
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  downstream control
flush  input  1  squash the instruction entering EX (branch/jump taken)
exmem_reg_write  input  1  EX/MEM instruction writes a register
exmem_write_reg  input  REG_ADDR_W  EX/MEM destination
exmem_alu_out  input  DATA_W  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB instruction writes a register
memwb_write_reg  input  REG_ADDR_W  MEM/WB destination
memwb_data  input  DATA_W  MEM/WB write-back data
stall  output  1  load-use hazard; PC and IF/ID must hold
ALU_reg_1  output  DATA_W  ALU operand A
ALU_reg_2  output  DATA_W  ALU operand B
ALU_control  output  CTRL_W  ALU operation code
shamt  output  5  ALU shift amount
ex_store_data  output  DATA_W  forwarded rt value, for stores
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered control
ex_write_reg  output  REG_ADDR_W  registered destination

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n.
  - While rst_n=0, every registered field is 0.
  - Consequently ex_valid=0, all ex_* controls=0, ALU_control=4'b0000, shamt=0, ALU_reg_1/ALU_reg_2/ex_store_data=0, and stall=0.
  - Reset is asserted immediately (not clocked) and deasserted cleanly on the next rising edge. A reset arriving mid-stall discards the pending instruction.
- Load-use hazard:
  - stall = id_valid & ex_valid & ex_mem_read & (ex_write_reg != 0) & (id_rs == ex_write_reg | id_rt == ex_write_reg) & ~flush.
  - stall is combinational.
- Register update, each rising edge, in priority order:
  - flush=1 or stall=1: load a bubble. All fields are zero, so valid=0 and no write, no memory access, ALU_control=0000.
  - Otherwise: load all id_* fields, with ex_valid=id_valid.
  - id_valid=0 loads fields as given, but reg_write/mem_read/mem_write are forced to 0.
- Stall handling: a stall produces exactly one bubble per hazard. The next cycle, the held decode instruction re-evaluates and normally proceeds. The block does not hold its own register on stall.
- Forwarding: combinational on the registered rs/rt, evaluated separately for A (rs) and B (rt).
  - EX/MEM match (exmem_reg_write & exmem_write_reg != 0 & index equal) selects exmem_alu_out.
  - Otherwise a MEM/WB match under the same rule selects memwb_data.
  - Otherwise the registered register-file data is used.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - ALU_reg_1 = forwarded A.
  - ex_store_data = forwarded B.
  - ALU_reg_2 = registered imm when alu_src=1, else forwarded B.
  - ALU_control and shamt come straight from the register.
- Latency: one cycle from id_* to EX outputs. Forwarded values reflect the current-cycle EX/MEM and MEM/WB inputs, with zero added latency.

Test Plan:
- Reset: drive rst_n low mid-cycle with all id_* nonzero -> all outputs read 0 immediately, stall=0. After release, the first edge loads the id_* fields.
- Pass-through: id_rs_data=5, id_rt_data=7, alu_src=0, alu_control=0010, no forwarding matches -> next cycle ALU_reg_1=5, ALU_reg_2=7, ALU_control=0010. Repeat with alu_src=1, imm=0xFFFFFFFC -> ALU_reg_2=0xFFFFFFFC.
- Forward priority: EX rs=rt=8; exmem (1,8,0x11) and memwb (1,8,0x22) both match -> ALU_reg_1=ALU_reg_2=0x11. With exmem_reg_write=0 -> both 0x22. With index 0 and both matching -> the register-file values are used.
- Load-use: EX holds lw to r9 (mem_read=1), ID instruction has rt=9 -> stall=1. Next edge gives ex_valid=0, reg_write=0, mem_write=0. The following cycle, with memwb matching r9=0xABCD, ALU_reg_2=0xABCD.
- Flush versus stall: load-use condition plus flush=1 -> stall=0, and the next edge loads a bubble. flush=1 with no hazard -> bubble as well.
- Store data: sw with alu_src=1, rt matching exmem=0x55 -> ALU_reg_2=imm, ex_store_data=0x55.
